instr_fetch_mem: RTL and testbench
==================================

Name: instr_fetch_mem

Overview:
Parametrised, clocked instruction memory for the pipelined processor's IF stage. Replaces the combinational fetch with a 1-cycle registered read behind a valid/ready request port and a stallable, flushable response. Adds a program-load write port, a hardware clear-to-HALT sequence after reset, and fault reporting for misaligned or out-of-range fetches. Also splits opcode and funct fields for the decoder.

Parameters:
DATA_W, 32, instruction width in bits (≥ 32; ctr and funcode are taken from the low 32-bit layout).
ADDR_W, 32, byte-address width of fetch PC.
DEPTH, 128, number of instruction words (power of 2, ≥ 2).
HALT_WORD, 32'hFC000000, fill and fault word (opcode 6'b111111).
BUBBLE_WORD, 32'h00000000, word presented after flush (sll nop).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  synchronous active-low reset, sampled on rising clk.
req_valid  in  1  fetch request present.
req_addr  in  ADDR_W  byte PC of the fetch.
req_ready  out  1  fetch accepted this cycle when req_valid & req_ready.
rsp_valid  out  1  instr/ctr/funcode/fault hold a fetched result.
rsp_stall  in  1  downstream stall, response must hold.
flush  in  1  discard the in-flight or held response.
instr  out  DATA_W  fetched word.
ctr  out  6  instr[31:26].
funcode  out  6  instr[5:0].
fault  out  1  response came from a misaligned or out-of-range address.
ld_we  in  1  program-load write strobe.
ld_addr  in  $clog2(DEPTH)  word index to write.
ld_data  in  DATA_W  word to write.
ld_ready  out  1  load port accepting writes.
busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst_n=0 at a rising edge): state<=CLEAR, clear counter<=0, rsp_valid=0, instr=HALT_WORD, ctr=6'h3F, funcode=0, fault=0, busy=1, req_ready=0, ld_ready=0. Reset asserted mid-operation aborts any fetch, load, or clear immediately.
- CLEAR: writes HALT_WORD to mem[counter], one word per cycle. After the write of DEPTH-1, the next state is RUN, so busy=1 for exactly DEPTH cycles after reset deasserts. Requests and loads are ignored.
- RUN: busy=0 and ld_ready=1.
  - req_ready = !(rsp_valid & rsp_stall).
  - On an accepted request, the response appears on the next edge with rsp_valid=1. Latency is 1 cycle. Back-to-back fetches give one result per cycle.
- Address handling, where word index = req_addr>>2:
  - Misaligned (req_addr[1:0]≠0) or index ≥ DEPTH: instr=HALT_WORD, fault=1.
  - req_addr == all-ones−3 (PC init sentinel −4): instr=HALT_WORD, fault=0.
  - Otherwise: instr=mem[index], fault=0.
- ctr and funcode are always the registered slices of instr.
- Stall: while rsp_valid & rsp_stall, instr/ctr/funcode/fault/rsp_valid hold and no request is accepted.
- Flush: the next edge forces rsp_valid=0, instr=BUBBLE_WORD, fault=0. A request accepted in the flush cycle is dropped. Flush overrides stall.
- No request accepted and no stall: rsp_valid<=0 and instr holds its last value.
- Load: in RUN, ld_we writes mem[ld_addr]<=ld_data at the edge. In CLEAR, ld_we is ignored.
- Same-cycle load and fetch of the same word: the fetch returns the OLD contents (read-before-write). The new word is visible from the next fetch.

Test Plan:
- Reset, release, poll busy -> busy high exactly 128 cycles; fetch 0x00 -> instr=0xFC000000, ctr=0x3F, fault=0, rsp_valid 1 cycle after accept.
- Load words 0..3 = 0x20080005, 0x00000020, 0x1109FFFE, 0xAC080004; fetch 0x0,0x4,0x8,0xC back-to-back -> same words on 4 consecutive cycles; funcode of word 1 = 0x20.
- Fetch 0x4 with rsp_stall high 3 cycles -> instr=0x00000020 held, req_ready=0 throughout; release -> the next queued request is accepted.
- Fetch 0x202 -> fault=1, instr=0xFC000000. Fetch 0x200 (index 128) -> fault=1. Fetch 0xFFFFFFFC -> instr=0xFC000000, fault=0.
- Same-cycle ld_we to index 2 with 0x12345678 plus fetch 0x8 -> old 0x1109FFFE; refetch -> 0x12345678. Flush with stall asserted -> rsp_valid=0, instr=0x00000000.
- Assert rst_n=0 mid-stream during RUN -> next edge rsp_valid=0, busy=1; loaded words are overwritten with HALT after the clear completes.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// IF-stage instruction memory: one-cycle registered fetch behind a valid/ready port,
// stallable/flushable response, program-load port and a clear-to-HALT sweep after reset.
module instr_fetch_mem #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 128,
  parameter logic [DATA_W-1:0] HALT_WORD   = DATA_W'(32'hFC00_0000),
  parameter logic [DATA_W-1:0] BUBBLE_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_stall,
  input  logic                     flush,
  output logic [DATA_W-1:0]        instr,
  output logic [5:0]               ctr,
  output logic [5:0]               funcode,
  output logic                     fault,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  output logic                     busy
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q;
  logic              fault_q;
  logic [DATA_W-1:0] instr_q;

  logic              in_run;
  logic              hold;
  logic              accept;
  logic [IDX_W-1:0]  rd_idx;
  logic              addr_sentinel;
  logic              addr_bad;
  logic [DATA_W-1:0] rd_word;
  logic              rd_fault;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_nxt = state;
    busy      = 1'b1;
    ld_ready  = 1'b0;
    in_run    = 1'b0;
    unique case (state)
      ST_CLEAR: if (clr_cnt == LAST_IDX) state_nxt = ST_RUN;
      ST_RUN: begin
        busy     = 1'b0;
        ld_ready = 1'b1;
        in_run   = 1'b1;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign hold      = rsp_valid_q & rsp_stall;
  assign req_ready = in_run & ~hold;
  assign accept    = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Address decode and read
  // ---------------------------------------------------------------------------
  assign rd_idx        = req_addr[IDX_W+1:2];
  assign addr_sentinel = (req_addr == {{(ADDR_W-2){1'b1}}, 2'b00});
  assign addr_bad      = (req_addr[1:0] != 2'b00) | (|req_addr[ADDR_W-1:IDX_W+2]);

  // The PC-init sentinel is out of range too, so it must win over the fault path.
  always_comb begin
    rd_word  = mem[rd_idx];
    rd_fault = 1'b0;
    if (addr_sentinel) begin
      rd_word = HALT_WORD;
    end else if (addr_bad) begin
      rd_word  = HALT_WORD;
      rd_fault = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: the clear sweep and program loads share the single write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it maps to RAM; the CLEAR sweep
    // initialises it instead.
    if (rst_n) begin
      if (state == ST_CLEAR) mem[clr_cnt] <= HALT_WORD;
      else if (ld_we)        mem[ld_addr] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register: flush beats stall, stall beats a new fetch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      instr_q     <= HALT_WORD;
      fault_q     <= 1'b0;
    end else if (flush) begin
      rsp_valid_q <= 1'b0;
      instr_q     <= BUBBLE_WORD;
      fault_q     <= 1'b0;
    end else if (hold) begin
      rsp_valid_q <= rsp_valid_q;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      instr_q     <= rd_word;
      fault_q     <= rd_fault;
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign instr     = instr_q;
  assign fault     = fault_q;
  assign ctr       = instr_q[31:26];
  assign funcode   = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: driver pushes reference-model expectations,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_instr_fetch_mem;

  localparam logic [31:0] HALT   = 32'hFC00_0000;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
  localparam int          WORDS  = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_stall;
  logic        flush;
  logic [31:0] instr;
  logic [5:0]  ctr;
  logic [5:0]  funcode;
  logic        fault;
  logic        ld_we;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        busy;

  instr_fetch_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_stall (rsp_stall),
    .flush     (flush),
    .instr     (instr),
    .ctr       (ctr),
    .funcode   (funcode),
    .fault     (fault),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    bit          flt;
    int          cyc;
    bit          seen;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [WORDS];
  bit          m_run     = 1'b0;
  bit          m_valid   = 1'b0;
  bit          exp_ready = 1'b0;
  bit          after_reset = 1'b0;
  bit          after_flush = 1'b0;
  int          cyc    = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference fetch behaviour straight from the address rules.
  function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] w, output bit f);
    if (a == 32'hFFFF_FFFC) begin
      w = HALT; f = 1'b0;
    end else if (a[1:0] != 2'b00 || a[31:9] != 23'd0) begin
      w = HALT; f = 1'b1;
    end else begin
      w = ref_mem[a[8:2]]; f = 1'b0;
    end
  endfunction

  // One clock of stimulus; called just after a rising edge, returns just after the next.
  task automatic step(input bit rv, input logic [31:0] a, input bit st, input bit fl,
                      input bit we, input logic [6:0] la, input logic [31:0] ld, input bit rn);
    bit          acc;
    exp_t        e;
    logic [31:0] w;
    bit          f;
    rst_n = rn; req_valid = rv; req_addr = a; rsp_stall = st; flush = fl;
    ld_we = we; ld_addr = la; ld_data = ld;
    exp_ready = m_run && !(m_valid && st);
    acc = rv && exp_ready;
    if (acc && !fl && rn) begin
      ref_fetch(a, w, f);
      e.word = w; e.flt = f; e.cyc = cyc + 1; e.seen = 1'b0;
      sb.push_back(e);
    end
    if (we && m_run && rn) ref_mem[la] = ld;
    if (!rn)                  begin m_valid = 1'b0; m_run = 1'b0; end
    else if (fl)              m_valid = 1'b0;
    else if (!(m_valid && st)) m_valid = acc;
    @(posedge clk);
    #1;
    if (!rn) begin
      sb.delete();
      for (int i = 0; i < WORDS; i++) ref_mem[i] = HALT;
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1);
  endtask

  task automatic load(input logic [6:0] la, input logic [31:0] ld);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, la, ld, 1'b1);
  endtask

  // Release reset and count busy cycles while throwing ignored requests/loads at it.
  task automatic release_and_clear();
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step(1'($urandom), $urandom, 1'b0, 1'b0, 1'($urandom), 7'($urandom), $urandom, 1'b1);
    end
    check("busy_cycles", n, WORDS);
    m_run = 1'b1;
  endtask

  task automatic random_traffic(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : {23'd0, 7'($urandom), 2'b00};
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0, 7'($urandom), $urandom, 1'b1);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (after_reset) begin
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_instr", instr, HALT);
      check("rst_ctr", ctr, 6'h3F);
      check("rst_funcode", funcode, 6'h00);
      check("rst_fault", fault, 1'b0);
      check("rst_ld_ready", ld_ready, 1'b0);
    end
    if (after_flush) begin
      check("flush_rsp_valid", rsp_valid, 1'b0);
      check("flush_instr", instr, BUBBLE);
      check("flush_fault", fault, 1'b0);
    end
    check("req_ready", req_ready, exp_ready);
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_valid_spurious", rsp_valid, 1'b0);
      end else begin
        e = sb[0];
        if (!e.seen) check("latency", cyc, e.cyc);
        check("instr", instr, e.word);
        check("fault", fault, e.flt);
        check("ctr", ctr, e.word[31:26]);
        check("funcode", funcode, e.word[5:0]);
        e.seen = 1'b1;
        sb[0] = e;
        if (flush || !rsp_stall) void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      check("rsp_missing", rsp_valid, 1'b1);
      void'(sb.pop_front());
    end
    after_reset = !rst_n;
    after_flush = flush && rst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_stall = 1'b0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = HALT;

    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
    release_and_clear();

    fetch(32'h0);
    idle();

    load(7'd0, 32'h2008_0005);
    load(7'd1, 32'h0000_0020);
    load(7'd2, 32'h1109_FFFE);
    load(7'd3, 32'hAC08_0004);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle();

    // Stall a response for three cycles with a request waiting behind it.
    fetch(32'h4);
    repeat (3) step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1);
    fetch(32'hC);
    idle();

    fetch(32'h202); fetch(32'h200); fetch(32'hFFFF_FFFC); fetch(32'h1FC); fetch(32'hFFFF_FFFF);
    idle();

    // Same-cycle load and fetch of one word returns the old contents.
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 7'd2, 32'h1234_5678, 1'b1);
    fetch(32'h8);
    idle();

    // Flush over a stalled response, then flush dropping a fresh accept.
    fetch(32'h4);
    step(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 1'b1);
    idle();
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 7'd0, 32'd0, 1'b1);
    idle();

    random_traffic(250);

    // Reset mid-stream, then confirm the loaded program was wiped.
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
    release_and_clear();
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle();

    random_traffic(100);
    repeat (3) idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
